// File: rtl/alu_sequencer_if.sv
// Handshake and ALU-facing bus of the ALU sequencer.
// The slave side is the sequencer; the master side is the control unit and register file together with the ALU.
interface alu_sequencer_if #(
  parameter int wordSize = 32
);
  logic                    start;
  logic [4:0]              opcode;
  logic [wordSize-1:0]     ra_data;
  logic [wordSize-1:0]     rb_data;
  logic [2*wordSize-1:0]   alu_C;
  logic [wordSize-1:0]     alu_A;
  logic [wordSize-1:0]     alu_B;
  logic [4:0]              alu_opcode;
  logic [wordSize-1:0]     lo_out;
  logic [wordSize-1:0]     hi_out;
  logic                    lo_we;
  logic                    hi_we;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [15:0]             op_count;

  modport slave (
    input  start, opcode, ra_data, rb_data, alu_C,
    output alu_A, alu_B, alu_opcode, lo_out, hi_out,
           lo_we, hi_we, busy, done, err, op_count
  );

  modport master (
    output start, opcode, ra_data, rb_data, alu_C,
    input  alu_A, alu_B, alu_opcode, lo_out, hi_out,
           lo_we, hi_we, busy, done, err, op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer. It latches a request, waits an opcode-dependent number of cycles,
// and writes the result into the HI/LO registers it owns.
module alu_sequencer #(
  parameter int wordSize   = 32,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic           clk,
  input  logic           clr,
  alu_sequencer_if.slave bus
);
  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_DONE} state_t;

  state_t              r_state;
  logic [4:0]          r_op;
  logic [CNT_W-1:0]    r_cnt;
  logic [wordSize-1:0] r_alu_a;
  logic [wordSize-1:0] r_alu_b;
  logic [4:0]          r_alu_op;
  logic [wordSize-1:0] r_lo;
  logic [wordSize-1:0] r_hi;
  logic                r_lo_we;
  logic                r_hi_we;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [15:0]         r_op_count;

  logic             w_illegal;
  logic             w_div0;
  logic             w_skip;
  logic             w_wide;
  logic [CNT_W-1:0] w_load;

  assign w_illegal = bus.opcode > 5'd15;
  assign w_div0    = (bus.opcode == OP_DIV) && (bus.rb_data == '0);
  assign w_skip    = w_illegal || w_div0 || (bus.opcode == OP_NOP);
  // HI is written only by the double-width operations.
  assign w_wide    = (r_op == OP_MUL) || (r_op == OP_DIV);
  assign w_load    = (bus.opcode == OP_MUL) ? CNT_W'(MUL_CYCLES) :
                     (bus.opcode == OP_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(1);

  // NOTE: every register is cleared by reset, so an abandoned operation leaves no trace.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_lo_we    <= 1'b0;
      r_hi_we    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_op_count <= '0;
    end else begin
      // NOTE: non-blocking defaults make the strobes one cycle wide; the state arms below override them.
      r_lo_we <= 1'b0;
      r_hi_we <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_alu_a <= bus.ra_data;
            r_alu_b <= bus.rb_data;
            r_op    <= bus.opcode;
            r_busy  <= 1'b1;
            if (w_skip) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_err      <= w_illegal || w_div0;
              r_op_count <= r_op_count + 16'd1;
            end else begin
              r_state  <= S_EXEC;
              r_alu_op <= bus.opcode;
              r_cnt    <= w_load;
            end
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_WB;
            r_lo_we <= 1'b1;
            r_hi_we <= w_wide;
          end
        end
        S_WB: begin
          r_lo <= bus.alu_C[wordSize-1:0];
          if (w_wide) r_hi <= bus.alu_C[2*wordSize-1:wordSize];
          r_state    <= S_DONE;
          r_done     <= 1'b1;
          r_alu_op   <= '0;
          r_op_count <= r_op_count + 16'd1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_A      = r_alu_a;
  assign bus.alu_B      = r_alu_b;
  assign bus.alu_opcode = r_alu_op;
  assign bus.lo_out     = r_lo;
  assign bus.hi_out     = r_hi;
  assign bus.lo_we      = r_lo_we;
  assign bus.hi_we      = r_hi_we;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.op_count   = r_op_count;
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sequences one ALU operation at a time. It latches operands and opcode on a start handshake, drives the ALU inputs, and waits an opcode-dependent number of cycles (multiply and divide are slow paths). It then writes the 64-bit result into HI/LO registers and pulses done. It sits between the control unit / register file read ports and the ALU, and owns the HI/LO result registers.

Parameters:
wordSize, 32, operand width; the result is 2*wordSize.
MUL_CYCLES, 4, EXEC cycles allowed for mul (must be >= 1).
DIV_CYCLES, 8, EXEC cycles allowed for div (must be >= 1).

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  asynchronous, active-high reset.
start  in  1  request to execute; sampled only in IDLE.
opcode  in  5  ALU opcode; encoding 0..15 as the ALU defines (nop=0, mul=3, div=4).
ra_data  in  wordSize  operand A.
rb_data  in  wordSize  operand B.
alu_C  in  2*wordSize  ALU result (combinational from alu_A/alu_B/alu_opcode).
alu_A  out  wordSize  latched operand A to the ALU.
alu_B  out  wordSize  latched operand B to the ALU.
alu_opcode  out  5  opcode to the ALU; 0 unless in EXEC or WB.
lo_out  out  wordSize  LO register.
hi_out  out  wordSize  HI register.
lo_we  out  1  one-cycle strobe: LO updated this cycle.
hi_we  out  1  one-cycle strobe: HI updated this cycle.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  valid with done: illegal opcode or divide by zero.
op_count  out  16  number of completed operations, wraps at 0xFFFF->0.

Behaviour:
- Reset (clr=1, asynchronous):
  - State goes to IDLE.
  - alu_A, alu_B, alu_opcode, lo_out, hi_out, op_count are 0; lo_we, hi_we, busy, done, err are 0.
  - Reset mid-operation abandons the operation: no writes, no done.
- States: IDLE, EXEC, WB, DONE.
- IDLE: when start=1 at a clock edge, latch ra_data, rb_data, opcode into alu_A, alu_B, and an internal opcode register.
  - Illegal opcode (opcode > 15), nop, or div with rb_data == 0: go directly to DONE. err=1 for the illegal and divide-by-zero cases, err=0 for nop. No HI/LO write.
  - Otherwise load the wait counter (MUL_CYCLES for mul, DIV_CYCLES for div, 1 for everything else) and go to EXEC.
- EXEC: drive alu_opcode from the latched opcode and decrement the counter each cycle. When the counter reaches 1, go to WB on the next edge.
- WB (one cycle): alu_opcode is still driven.
  - lo_out <= alu_C[wordSize-1:0] with lo_we=1.
  - For mul/div only, hi_out <= alu_C[2*wordSize-1:wordSize] with hi_we=1; hi_out is unchanged for other opcodes.
  - Next state is DONE.
- DONE (one cycle): done=1, busy=1, alu_opcode=0. op_count increments on every done, including error and nop completions. Next state is IDLE.
- Latency: with start accepted at edge 0, an L-cycle op occupies EXEC for cycles 1..L, WB in cycle L+1, and DONE in cycle L+2. Ops that skip EXEC and WB reach DONE in cycle 1.
- start while busy is ignored; it is not queued. Operand or opcode inputs changing during EXEC have no effect.
- err is cleared in IDLE. lo_we, hi_we, and done are never asserted outside their state.
- alu_A and alu_B hold their values until the next accepted start.

Test Plan:
- Single-cycle add: start at edge 0 with opcode=1, A=5, B=7. Required: lo_we=1 in cycle 2; lo_out=12 after it; hi_we=0; done=1 in cycle 3; err=0; op_count=1.
- mul, MUL_CYCLES=4: A=0x10000, B=0x10000. Required: EXEC for cycles 1..4; WB in cycle 5 with hi_out=0x1 and lo_out=0x0; done in cycle 6.
- div by zero: opcode=4, B=0. Required: done=1 and err=1 in cycle 1; lo_out and hi_out unchanged; lo_we=hi_we=0; op_count increments.
- Illegal opcode 5'b10101, then nop. Required: each gives done in cycle 1, with err=1 for the illegal opcode and err=0 for nop, and no writes.
- start held high during a div with DIV_CYCLES=8. Required: the second request is ignored until IDLE; an operand change mid-EXEC does not alter the result.
- clr pulsed in EXEC cycle 2 of a mul. Required: all outputs are 0 immediately, and no done follows. A following add completes normally, with op_count=1.
